// File: rtl/horizontal_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : horizontal_counter_pkg
// Brief    : Phase encoding and 640x480@60 timing constants shared by the
//            horizontal and vertical timing stages.
// Revision : 1.0
// ============================================================================
package horizontal_counter_pkg;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FP     = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BP     = 2'd3
    } phase_t;

    function automatic int timing_total(input int active, input int fp,
                                        input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int c_h_active = 640;
    localparam int c_h_fp     = 16;
    localparam int c_h_sync   = 96;
    localparam int c_h_bp     = 48;
    localparam int c_h_total  = timing_total(c_h_active, c_h_fp, c_h_sync, c_h_bp);

    localparam int c_v_active = 480;
    localparam int c_v_fp     = 10;
    localparam int c_v_sync   = 2;
    localparam int c_v_bp     = 33;
    localparam int c_v_total  = timing_total(c_v_active, c_v_fp, c_v_sync, c_v_bp);

    localparam int c_x_width  = 10;

endpackage : horizontal_counter_pkg
`default_nettype wire

// File: rtl/horizontal_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : horizontal_counter_if
// Brief    : Pixel enable in, line timing out of the horizontal stage.
// Revision : 1.0
// ============================================================================
interface horizontal_counter_if;
    import horizontal_counter_pkg::*;

    logic                   pixel_en;
    logic                   hsync;
    logic                   hactive;
    logic [c_x_width-1:0]   x;
    logic                   line_end;
    phase_t                 phase;

    modport master (
        input  pixel_en,
        output hsync,
        output hactive,
        output x,
        output line_end,
        output phase
    );

    modport slave (
        output pixel_en,
        input  hsync,
        input  hactive,
        input  x,
        input  line_end,
        input  phase
    );

endinterface : horizontal_counter_if
`default_nettype wire

// File: rtl/horizontal_counter.sv
`default_nettype none
// ============================================================================
// Module   : horizontal_counter
// Brief    : Horizontal pixel counter with ACTIVE/FP/SYNC/BP phase FSM and
//            registered hsync/hactive/line_end outputs.
// Revision : 1.0
// ============================================================================
module horizontal_counter
    import horizontal_counter_pkg::*;
#(
    parameter int H_ACTIVE = c_h_active,
    parameter int H_FP     = c_h_fp,
    parameter int H_SYNC   = c_h_sync,
    parameter int H_BP     = c_h_bp
) (
    input  wire logic               clock,
    input  wire logic               res,
    horizontal_counter_if.master    bus
);

    localparam int c_total = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);

    // Last x value of each phase; the phase advances on the edge leaving it.
    localparam logic [c_x_width-1:0] c_active_last = c_x_width'(H_ACTIVE - 1);
    localparam logic [c_x_width-1:0] c_fp_last     = c_x_width'(H_ACTIVE + H_FP - 1);
    localparam logic [c_x_width-1:0] c_sync_last   = c_x_width'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [c_x_width-1:0] c_line_last   = c_x_width'(c_total - 1);

    logic [c_x_width-1:0]   r_x;
    phase_t                 r_phase;
    logic                   r_hsync;
    logic                   r_hactive;
    logic                   r_line_end;

    always_ff @(posedge clock) begin
        if (res) begin
            r_x        <= '0;
            r_phase    <= PH_ACTIVE;
            r_hsync    <= 1'b1;
            r_hactive  <= 1'b1;
            r_line_end <= 1'b0;
        end else begin
            r_line_end <= 1'b0;
            if (bus.pixel_en) begin
                r_x <= (r_x == c_line_last) ? '0 : r_x + 1'b1;
                // Outputs are decoded from the current x so they change on
                // the same edge as the new x, with no extra latency.
                case (r_phase)
                    PH_ACTIVE: begin
                        if (r_x == c_active_last) begin
                            r_phase   <= PH_FP;
                            r_hactive <= 1'b0;
                        end
                    end
                    PH_FP: begin
                        if (r_x == c_fp_last) begin
                            r_phase <= PH_SYNC;
                            r_hsync <= 1'b0;
                        end
                    end
                    PH_SYNC: begin
                        if (r_x == c_sync_last) begin
                            r_phase <= PH_BP;
                            r_hsync <= 1'b1;
                        end
                    end
                    PH_BP: begin
                        if (r_x == c_line_last) begin
                            r_phase    <= PH_ACTIVE;
                            r_hactive  <= 1'b1;
                            r_line_end <= 1'b1;
                        end
                    end
                    default: begin
                        r_phase <= PH_ACTIVE;
                    end
                endcase
            end
        end
    end

    assign bus.x        = r_x;
    assign bus.phase    = r_phase;
    assign bus.hsync    = r_hsync;
    assign bus.hactive  = r_hactive;
    assign bus.line_end = r_line_end;

endmodule : horizontal_counter
`default_nettype wire

// File: tb/tb_horizontal_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_horizontal_counter
// Brief    : Self-checking bench for horizontal_counter against a range-based
//            line timing model.
// Revision : 1.0
// ============================================================================
module tb_horizontal_counter;

    logic clock;
    logic res;
    int   n_assert;
    int   n_fail;

    // Reference model state: pixel position and pending line_end pulse
    int   m_x;
    bit   m_le;

    horizontal_counter_if hif ();

    horizontal_counter dut (
        .clock (clock),
        .res   (res),
        .bus   (hif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic en, input logic rs);
        int exp_phase;
        hif.pixel_en = en;
        res          = rs;
        @(posedge clock);
        if (rs) begin
            m_x  = 0;
            m_le = 1'b0;
        end else begin
            m_le = en && (m_x == 799);
            if (en) m_x = (m_x == 799) ? 0 : m_x + 1;
        end
        #1;
        if (m_x < 640)      exp_phase = 0;
        else if (m_x < 656) exp_phase = 1;
        else if (m_x < 752) exp_phase = 2;
        else                exp_phase = 3;
        chk("x",        32'(hif.x),        32'(m_x));
        chk("phase",    32'(hif.phase),    32'(exp_phase));
        chk("hactive",  32'(hif.hactive),  32'(m_x < 640));
        chk("hsync",    32'(hif.hsync),    32'(exp_phase != 2));
        chk("line_end", 32'(hif.line_end), 32'(m_le));
    endtask

    initial begin
        int   edge_n;
        int   fall, rise, le1, le2, low;
        logic prev_hs;

        n_assert     = 0;
        n_fail       = 0;
        m_x          = 0;
        m_le         = 1'b0;
        res          = 1'b1;
        hif.pixel_en = 1'b0;

        // Reset holds regardless of pixel_en
        for (int i = 0; i < 3; i++) step(1'($urandom_range(0, 1)), 1'b1);

        // First enabled edge after reset, then a continuous run
        step(1'b1, 1'b0);
        chk("first_x", 32'(hif.x), 32'd1);
        edge_n  = 1;
        fall    = -1;
        rise    = -1;
        le1     = -1;
        le2     = -1;
        prev_hs = hif.hsync;
        for (int i = 0; i < 1604; i++) begin
            step(1'b1, 1'b0);
            edge_n++;
            if (prev_hs === 1'b1 && hif.hsync === 1'b0 && fall < 0) fall = edge_n;
            if (prev_hs === 1'b0 && hif.hsync === 1'b1 && rise < 0) rise = edge_n;
            if (hif.line_end === 1'b1) begin
                if (le1 < 0) le1 = edge_n;
                else if (le2 < 0) le2 = edge_n;
            end
            prev_hs = hif.hsync;
        end
        chk("hsync_fall_edge", 32'(fall), 32'd656);
        chk("hsync_low_edges", 32'(rise - fall), 32'd96);
        chk("first_line_end",  32'(le1), 32'd800);
        chk("line_period",     32'(le2 - le1), 32'd800);

        // 1-in-2 enable
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        le1 = -1;
        le2 = -1;
        low = 0;
        for (int c = 1; c <= 3200; c++) begin
            step(1'(c % 2), 1'b0);
            if (le1 < 0 && hif.hsync === 1'b0) low++;
            if (hif.line_end === 1'b1) begin
                if (le1 < 0) le1 = c;
                else if (le2 < 0) le2 = c;
            end
        end
        chk("half_rate_line_end",  32'(le1), 32'd1599);
        chk("half_rate_period",    32'(le2 - le1), 32'd1600);
        chk("half_rate_hsync_low", 32'(low), 32'd192);

        // Stall in front porch
        step(1'b0, 1'b1);
        for (int i = 0; i < 645; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 50; i++) step(1'b0, 1'b0);
        chk("stall_x",       32'(hif.x),       32'd645);
        chk("stall_phase",   32'(hif.phase),   32'd1);
        chk("stall_hactive", 32'(hif.hactive), 32'd0);
        chk("stall_hsync",   32'(hif.hsync),   32'd1);

        // Single enable at the last pixel
        for (int i = 0; i < 154; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("pre_wrap_x", 32'(hif.x), 32'd799);
        step(1'b1, 1'b0);
        chk("wrap_x",        32'(hif.x),        32'd0);
        chk("wrap_phase",    32'(hif.phase),    32'd0);
        chk("wrap_hactive",  32'(hif.hactive),  32'd1);
        chk("wrap_line_end", 32'(hif.line_end), 32'd1);
        step(1'b0, 1'b0);
        chk("line_end_drop", 32'(hif.line_end), 32'd0);
        step(1'b0, 1'b0);
        chk("line_end_stays_low", 32'(hif.line_end), 32'd0);

        // Reset during sync
        for (int i = 0; i < 700; i++) step(1'b1, 1'b0);
        chk("mid_sync_hsync", 32'(hif.hsync), 32'd0);
        step(1'($urandom_range(0, 1)), 1'b1);
        chk("rst_sync_x",       32'(hif.x),       32'd0);
        chk("rst_sync_hsync",   32'(hif.hsync),   32'd1);
        chk("rst_sync_hactive", 32'(hif.hactive), 32'd1);
        step(1'b1, 1'b0);
        chk("post_rst_x", 32'(hif.x), 32'd1);

        // Random enables with rare resets
        for (int i = 0; i < 3000; i++)
            step(1'(($urandom % 4) != 0), 1'(($urandom % 600) == 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_horizontal_counter
`default_nettype wire
